fifo_wr_ctrl: RTL and testbench
===============================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 The module SHALL have parameter PTR_WD, default 4, giving the pointer width; FIFO depth is 2^(PTR_WD-1), i.e. 8 at default.
REQ-002 The module SHALL have parameter AF_THRESH, default 6, giving the almost-full occupancy threshold (1..depth).
REQ-003 W_CLK  in  1  write-domain clock; all state updates on its rising edge.
REQ-004 W_RST  in  1  reset, asynchronous, active-low.
REQ-005 W_INC  in  1  write request from the producer.
REQ-006 OVF_CLR  in  1  synchronous clear of the OVERFLOW flag.
REQ-007 r2w_ptr  in  PTR_WD  Gray read pointer, already synchronized into W_CLK.
REQ-008 gray_wr_ptr  out  PTR_WD  registered Gray write pointer, for synchronization into the read domain.
REQ-009 wr_addr  out  PTR_WD-1  memory write address, equal to binary pointer bits [PTR_WD-2:0].
REQ-010 W_EN  out  1  memory write strobe.
REQ-011 FULL  out  1  registered full flag.
REQ-012 ALMOST_FULL  out  1  occupancy >= AF_THRESH.
REQ-013 wr_level  out  PTR_WD  write-side occupancy, range 0..depth.
REQ-014 OVERFLOW  out  1  sticky flag: a write was attempted while full.

Function
REQ-015 Internal state SHALL be a binary pointer wr_bin[PTR_WD-1:0] plus the registered gray_wr_ptr, FULL and OVERFLOW.
REQ-016 W_EN SHALL be the combinational value W_INC & ~FULL.
REQ-017 On each rising edge with W_EN=1, wr_bin SHALL increment by 1 modulo 2^PTR_WD; otherwise it SHALL hold.
REQ-018 wr_next SHALL be wr_bin+W_EN; gray_next SHALL be wr_next ^ (wr_next>>1), with generic conversion and no lookup table.
REQ-019 gray_wr_ptr SHALL be registered from gray_next every cycle, so it changes by exactly one bit per write.
REQ-020 FULL SHALL be registered every cycle as (gray_next == {~r2w_ptr[PTR_WD-1:PTR_WD-2], r2w_ptr[PTR_WD-3:0]}); it asserts the same edge the depth-th unread write is accepted and deasserts one cycle after r2w_ptr advances.
REQ-021 wr_level SHALL be combinational: (wr_bin − gray2bin(r2w_ptr)) mod 2^PTR_WD, where gray2bin is the generic XOR-prefix conversion.
REQ-022 ALMOST_FULL SHALL be combinational: wr_level >= AF_THRESH.
REQ-023 OVERFLOW SHALL set on any edge with W_INC=1 and FULL=1 and clear on an edge with OVF_CLR=1; if both occur on the same edge, set wins.
REQ-024 A write attempted while full SHALL be dropped: pointer unchanged and W_EN=0.
REQ-025 Pointer wrap SHALL be seamless: wr_bin rolls over from 2^PTR_WD−1 to 0 and gray_next from 100..0 to 000..0, with no flag glitch.
REQ-026 When r2w_ptr changes and a write is accepted on the same edge, FULL SHALL be computed from both updated values (gray_next and current r2w_ptr).
REQ-027 wr_level and ALMOST_FULL SHALL reflect stale (synchronized) read progress only, and so are conservative: they never under-report occupancy.

Reset
REQ-028 While W_RST=0, the block SHALL hold wr_bin=0, gray_wr_ptr=0, FULL=0 and OVERFLOW=0, regardless of clock.
REQ-029 With r2w_ptr=0 during reset, the outputs SHALL be wr_addr=0, wr_level=0, ALMOST_FULL=0, and W_EN=W_INC.
REQ-030 Reset asserted mid-burst SHALL discard all pointer state immediately; the first write after deassertion SHALL go to wr_addr=0.

Verification (PTR_WD=4, AF_THRESH=6)
REQ-031 Reset, r2w_ptr=0, then 8 cycles of W_INC=1 -> wr_addr runs 0..7; gray_wr_ptr ends at 4'b1100; FULL=1 after the 8th edge; wr_level=8; ALMOST_FULL=1 from wr_level=6.
REQ-032 FULL=1, W_INC=1 for 2 cycles -> W_EN=0, wr_bin stays at 8, OVERFLOW=1 and held; OVF_CLR pulse with W_INC=0 -> OVERFLOW=0.
REQ-033 FULL, then r2w_ptr set to 4'b0001 -> FULL=0 on the next edge and wr_level=7; one write -> FULL=1 and gray_wr_ptr=4'b1101.
REQ-034 Wrap test: 20 writes interleaved with matching r2w_ptr advances -> wr_bin wraps 15->0, gray_wr_ptr goes 4'b1000->4'b0000, FULL never asserts, and gray_wr_ptr changes by one bit per write.
REQ-035 Same-edge W_INC=1 and OVF_CLR=1 while FULL -> OVERFLOW remains 1.
REQ-036 W_RST pulsed low after 5 writes -> gray_wr_ptr=0 and wr_addr=0 asynchronously; the next write lands at wr_addr=0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for an asynchronous FIFO: binary/Gray write pointer,
// registered full flag, conservative occupancy, almost-full and sticky overflow.
module fifo_wr_ctrl #(
  parameter int unsigned PTR_WD    = 4,
  parameter int unsigned AF_THRESH = 6
) (
  input  logic              W_CLK,
  input  logic              W_RST,
  input  logic              W_INC,
  input  logic              OVF_CLR,
  input  logic [PTR_WD-1:0] r2w_ptr,
  output logic [PTR_WD-1:0] gray_wr_ptr,
  output logic [PTR_WD-2:0] wr_addr,
  output logic              W_EN,
  output logic              FULL,
  output logic              ALMOST_FULL,
  output logic [PTR_WD-1:0] wr_level,
  output logic              OVERFLOW
);

  logic [PTR_WD-1:0] wr_bin_q, wr_bin_d;
  logic [PTR_WD-1:0] gray_q, gray_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic [PTR_WD-1:0] rd_bin;
  logic [PTR_WD-1:0] full_cmp;

  always_comb begin
    W_EN     = W_INC & ~full_q;
    wr_bin_d = wr_bin_q + {{(PTR_WD-1){1'b0}}, W_EN};
    gray_d   = wr_bin_d ^ (wr_bin_d >> 1);
    // Full when the next write pointer equals the read pointer with its two MSBs inverted.
    full_cmp = {~r2w_ptr[PTR_WD-1:PTR_WD-2], r2w_ptr[PTR_WD-3:0]};
    full_d   = (gray_d == full_cmp);
  end

  always_comb begin
    rd_bin = '0;
    rd_bin[PTR_WD-1] = r2w_ptr[PTR_WD-1];
    for (int unsigned i = 1; i < PTR_WD; i++) begin
      rd_bin[PTR_WD-1-i] = rd_bin[PTR_WD-i] ^ r2w_ptr[PTR_WD-1-i];
    end
  end

  always_comb begin
    wr_level    = wr_bin_q - rd_bin;
    ALMOST_FULL = (32'(wr_level) >= AF_THRESH);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (W_INC && full_q) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wr_bin_q <= '0;
      gray_q   <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_bin_q <= wr_bin_d;
      gray_q   <= gray_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign gray_wr_ptr = gray_q;
  assign wr_addr     = wr_bin_q[PTR_WD-2:0];
  assign FULL        = full_q;
  assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus random traffic checked
// against a counter-based model of writes accepted and reads observed.
module tb_fifo_wr_ctrl;
  localparam int PW    = 4;
  localparam int AF    = 6;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inc;
  logic          clr;
  logic [PW-1:0] r2w;
  logic [PW-1:0] gray_o;
  logic [PW-2:0] addr_o;
  logic          wen_o;
  logic          full_o;
  logic          af_o;
  logic [PW-1:0] lvl_o;
  logic          ovf_o;

  always #5 clk = ~clk;

  fifo_wr_ctrl #(.PTR_WD(PW), .AF_THRESH(AF)) dut (
    .W_CLK(clk), .W_RST(rst_n), .W_INC(inc), .OVF_CLR(clr), .r2w_ptr(r2w),
    .gray_wr_ptr(gray_o), .wr_addr(addr_o), .W_EN(wen_o), .FULL(full_o),
    .ALMOST_FULL(af_o), .wr_level(lvl_o), .OVERFLOW(ovf_o)
  );

  // Model: total writes accepted and total reads seen through r2w_ptr.
  int wcnt, rcnt;
  bit full_m, ovf_m;
  int n_chk, n_pass;

  function automatic logic [PW-1:0] to_gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n % (1 << PW));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic check_all();
    int lvl;
    lvl = wcnt - rcnt;
    chk("w_en",   32'(wen_o),  32'(inc && !full_m));
    chk("addr",   32'(addr_o), 32'(wcnt % DEPTH));
    chk("gray",   32'(gray_o), 32'(to_gray(wcnt)));
    chk("full",   32'(full_o), 32'(full_m));
    chk("ovf",    32'(ovf_o),  32'(ovf_m));
    chk("level",  32'(lvl_o),  32'(lvl));
    chk("afull",  32'(af_o),   32'(lvl >= AF));
  endtask

  task automatic cycle(input bit i_inc, input bit i_clr, input int adv);
    logic [PW-1:0] prev;
    bit en;
    inc = i_inc;
    clr = i_clr;
    if (rcnt + adv <= wcnt) rcnt += adv;
    r2w = to_gray(rcnt);
    #1;
    check_all();
    prev = gray_o;
    @(posedge clk);
    en = i_inc && !full_m;
    if (i_inc && full_m) ovf_m = 1'b1;
    else if (i_clr) ovf_m = 1'b0;
    wcnt += int'(en);
    full_m = ((wcnt - rcnt) == DEPTH);
    #1;
    chk("gray_step", $countones(prev ^ gray_o), 32'(en));
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    r2w   = '0;
    wcnt = 0; rcnt = 0; full_m = 1'b0; ovf_m = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; inc = 1'b1; clr = 1'b0; r2w = '0;
    wcnt = 0; rcnt = 0; full_m = 1'b0; ovf_m = 1'b0;
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 0);
    chk("fill_gray", 32'(gray_o), 32'h0000000C);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_lvl",  32'(lvl_o),  32'd8);
    // Writes while full, then clear
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    chk("ovf_set",   32'(ovf_o),  32'd1);
    chk("ovf_addr",  32'(addr_o), 32'd0);
    cycle(1'b0, 1'b1, 0);
    chk("ovf_clr",   32'(ovf_o),  32'd0);
    // Set wins over clear
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 0);
    chk("ovf_prio",  32'(ovf_o),  32'd1);
    cycle(1'b0, 1'b1, 0);
    // One read observed, then one write refills
    cycle(1'b0, 1'b0, 1);
    chk("rd_full",   32'(full_o), 32'd0);
    chk("rd_lvl",    32'(lvl_o),  32'd7);
    cycle(1'b1, 1'b0, 0);
    chk("refill_full", 32'(full_o), 32'd1);
    chk("refill_gray", 32'(gray_o), 32'h0000000D);

    // Wrap with matched reads
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, (rcnt < wcnt) ? 1 : 0);
    chk("wrap_cnt",  32'(wcnt), 32'd20);

    // Async reset mid-burst
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0);
    do_reset();
    chk("rst_gray",  32'(gray_o), 32'd0);
    chk("rst_addr",  32'(addr_o), 32'd0);
    cycle(1'b1, 1'b0, 0);
    chk("rst_next",  32'(addr_o), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            ($urandom_range(0, 2) == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
